// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing and command bytes.
// Used by both the host transmitter and the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned PS2_INHIBIT_CYCLES = 12000;
  localparam int unsigned PS2_RTS_CYCLES     = 200;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 2000000;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

  // Bits following the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus a falling-edge detector
// on the synchronised level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // The bus idles high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, ten device-clocked
// bits and the acknowledge check, driving the bus through open-drain enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned RTS_CYCLES     = PS2_RTS_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       shift_q, shift_d;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_s, clk_fall_s, data_s, data_fall_unused_s, timeout_s;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_clk_i),
    .level_o(clk_s),
    .fall_o (clk_fall_s)
  );

  ps2_sync_edge u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_data_i),
    .level_o(data_s),
    .fall_o (data_fall_unused_s)
  );

  assign timeout_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      tmo_q     <= {TMO_W{1'b0}};
      bit_q     <= 4'd0;
      shift_q   <= 10'd0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic; timeout takes priority over any bus event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = INHIBIT;
          cnt_d   = {CNT_W{1'b0}};
          shift_d = ps2_frame(tx_data);
        end else begin
          state_d = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d = RTS;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RTS: begin
        if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
          state_d = SEND;
          bit_d   = 4'd0;
          tmo_d   = {TMO_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout_s) begin
          state_d = IDLE;
        end else if (clk_fall_s) begin
          shift_d = {1'b0, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          state_d = (bit_q == 4'd9) ? ACK : SEND;
        end else begin
          state_d = SEND;
        end
      end
      ACK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout_s) begin
          state_d = IDLE;
        end else if (clk_fall_s) begin
          ack_d   = ~data_s;
          state_d = WAIT_IDLE;
        end else begin
          state_d = ACK;
        end
      end
      WAIT_IDLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout_s || (clk_s && data_s)) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    clk_oe_d  = (state_d == INHIBIT) || (state_d == RTS);
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE:    data_oe_d = 1'b0;
      INHIBIT: data_oe_d = (state_d == RTS);
      RTS:     data_oe_d = 1'b1;
      SEND: begin
        if (timeout_s) begin
          error_d = 1'b1;
        end else if (clk_fall_s) begin
          data_oe_d = ~shift_q[0];
        end else begin
          data_oe_d = data_oe_q;
        end
      end
      ACK: begin
        error_d = timeout_s;
      end
      WAIT_IDLE: begin
        if (timeout_s) begin
          error_d = 1'b1;
        end else if (state_d == IDLE) begin
          done_d  = ack_q;
          error_d = ~ack_q;
        end else begin
          error_d = 1'b0;
        end
      end
      default: data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with an open-drain bus and a
// behavioural PS/2 device model that clocks frames and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int RTSC = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_pull, dev_data_pull;
  logic       ps2_clk_pin, ps2_data_pin;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_pull);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_pull);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTSC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_pin),
    .ps2_data_i (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as it should appear on the wire: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (d[i] === 1'b1) ? 1 : 0;
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Handshake plus inhibit/request-to-send timing; returns in the first cycle with clk released.
  task automatic do_request(input logic [7:0] d);
    int k;
    int first_data;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("hs_ready", tx_ready, 1'b0);
    check("hs_busy", tx_busy, 1'b1);
    check("hs_clk_oe", ps2_clk_oe, 1'b1);
    k = 0;
    first_data = -1;
    while (ps2_clk_oe === 1'b1 && k < INH + RTSC + 10) begin
      if (ps2_data_oe === 1'b1 && first_data < 0) first_data = k;
      k++;
      @(negedge clk);
    end
    check("clk_low_len", k, INH + RTSC);
    check("data_rise", first_data, INH);
    check("start_bit_oe", ps2_data_oe, 1'b1);
  endtask

  // Device clocks ten bits; optional tx_valid injection, optional reset after a bit.
  task automatic device_frame(input int inject_at, input int abort_at, output logic [10:0] frame);
    frame = 11'd0;
    repeat (HALF) @(negedge clk);
    frame[0] = ps2_data_pin;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b0;
      if (i == inject_at) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      frame[i] = ps2_data_pin;
      repeat (HALF - 1) @(negedge clk);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
  endtask

  // Eleventh clock with optional ACK, then wait for the result pulse.
  task automatic finish_frame(input logic ack);
    int k;
    int d0;
    int e0;
    logic seen;
    d0 = done_cnt;
    e0 = err_cnt;
    dev_data_pull = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_pull = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_pull = 1'b0;
    @(negedge clk);
    dev_data_pull = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
        seen = 1'b1;
        check("pulse_ready", tx_ready, 1'b1);
        check("pulse_clk_oe", ps2_clk_oe, 1'b0);
        check("pulse_data_oe", ps2_data_oe, 1'b0);
      end
    end
    check("pulse_seen", seen, 1'b1);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("error_pulses", err_cnt - e0, ack ? 0 : 1);
  endtask

  task automatic full_frame(input logic [7:0] d, input logic ack, input int inject_at);
    logic [10:0] frame;
    do_request(d);
    device_frame(inject_at, 0, frame);
    check("frame_bits", frame, model_frame(d));
    finish_frame(ack);
  endtask

  initial begin
    logic [10:0] frame;
    int k;
    int d0;
    int e0;
    rst           = 1'b1;
    tx_data       = 8'h00;
    tx_valid      = 1'b0;
    dev_clk_pull  = 1'b0;
    dev_data_pull = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 1'b0);
    check("reset_data_oe", ps2_data_oe, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    check("reset_error", tx_error, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    full_frame(8'hF4, 1'b1, 0);
    full_frame(8'hFF, 1'b1, 0);
    full_frame(8'h5A, 1'b0, 0);

    // Device never clocks after release.
    do_request(8'hF4);
    e0 = err_cnt;
    k = 0;
    while (tx_error !== 1'b1 && k < TMO + 50) begin
      k++;
      @(negedge clk);
    end
    check("timeout_cycles", k, TMO);
    check("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("timeout_data_oe", ps2_data_oe, 1'b0);
    @(negedge clk);
    check("timeout_pulses", err_cnt - e0, 1);
    repeat (5) @(negedge clk);

    // Request during SEND must not disturb the frame in flight.
    full_frame(8'h3C, 1'b1, 3);

    // Reset after the fourth bit, then a clean retry.
    d0 = done_cnt;
    e0 = err_cnt;
    do_request(8'hF4);
    device_frame(0, 4, frame);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_error", err_cnt - e0, 0);
    check("abort_idle_ready", tx_ready, 1'b1);
    full_frame(8'hF4, 1'b1, 0);

    for (int n = 0; n < 4; n++) begin
      full_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port, the send-side counterpart of the mouse receive path. It takes one command byte, for example 0xF4 "enable data reporting" or 0xFF "reset", and runs the full host-initiated PS/2 sequence: clock inhibit, request-to-send, ten device-clocked bits, and the acknowledge check. It drives the PS2_CLK/PS2_DATA pins open-drain through output-enable lines; the tristate buffers live at the top level, next to the mouse controller. It reports success or failure with single-cycle pulses.

## Interface
Parameters:
- INHIBIT_CYCLES, 12000: clock-low inhibit time (120 µs at 100 MHz).
- RTS_CYCLES, 200: data-low setup before clock release (2 µs).
- TIMEOUT_CYCLES, 2000000: limit from clock release to final idle (20 ms).

Ports:
- clk, in, 1: 100 MHz system clock, the only clock.
- rst, in, 1: asynchronous, active-high reset.
- tx_data, in, 8: command byte.
- tx_valid, in, 1: request; accepted only when tx_ready=1.
- tx_ready, out, 1: high in IDLE.
- tx_busy, out, 1: high whenever not IDLE; the receiver ignores frames while it is high.
- tx_done, out, 1: one-cycle pulse when the device ACK is received.
- tx_error, out, 1: one-cycle pulse on missing ACK or timeout.
- ps2_clk_i, in, 1: raw PS2_CLK pin level (asynchronous).
- ps2_data_i, in, 1: raw PS2_DATA pin level (asynchronous).
- ps2_clk_oe, out, 1: 1 pulls PS2_CLK low; 0 releases it.
- ps2_data_oe, out, 1: 1 pulls PS2_DATA low; 0 releases it.

## Operation
- Inputs are synchronised with two flip-flops. A falling edge of PS2_CLK (`fall`) is detected on the synchronised clock.
- On handshake (tx_valid & tx_ready), latch {stop=1, parity=~^tx_data, tx_data} into a shift register. The parity makes the total count of ones odd.
- States:
  - IDLE: both oe=0.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES, then go to RTS.
  - RTS: clk_oe=1 and data_oe=1 (this is the start bit) for RTS_CYCLES. Then clk_oe=0, clear bit counter and timeout counter, go to SEND.
  - SEND: each `fall` sets data_oe = ~next bit, LSB first. Falls 1–8 carry data bits 0–7, fall 9 carries parity, fall 10 carries stop (data_oe=0).
  - ACK: on the next `fall` (11), sample synchronised data. A 0 means ACK; a 1 means NACK.
  - WAIT_IDLE: wait until synchronised clk=1 and data=1. Then pulse tx_done on ACK or tx_error on NACK, and go to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. At TIMEOUT_CYCLES: both oe=0, pulse tx_error, go to IDLE.
- tx_valid outside IDLE is ignored; there is no queue.
- rst asserted mid-frame: lines are released immediately, the FSM returns to IDLE, and no done/error pulse is produced.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0.
- All outputs are registered.
- Handshake cycle N: tx_ready=0, tx_busy=1, clk_oe=1 at N+1.
- clk_oe is low-driving for exactly INHIBIT_CYCLES+RTS_CYCLES cycles. data_oe rises at N+1+INHIBIT_CYCLES.
- Data update latency is 3 clk cycles after the pin's falling edge (2 for synchronisation, 1 to register). This is well inside the device's ≥30 µs clock-low phase.
- tx_done/tx_error occur one cycle after idle-bus detection. tx_ready returns to 1 in the same cycle as the pulse.
- If the timeout and `fall` happen in the same cycle, the timeout wins.

## Structure
- The shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - default timing constants;
  - the PS/2 command constants (0xFF reset, 0xF4 enable, 0xFA device ACK byte), also used by the receiver.
- Sub-module ps2_sync_edge: a 2-FF synchroniser plus a registered falling-edge detector, with one instance each for clock and data (the data instance uses only the synchronised level). It is reused by the receive path.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 kHz -> clk held low 120 µs, then data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; model ACKs -> tx_done pulse, tx_error=0.
- Send 0xFF -> data bits all 1, parity 1; ACK -> tx_done.
- Model omits ACK (data high at fall 11) -> tx_error pulse, no tx_done, both oe=0.
- Model never clocks after release -> tx_error exactly TIMEOUT_CYCLES after clk_oe falls, lines released.
- tx_valid pulsed with 0x00 during SEND -> ignored; the wire carries only the original byte.
- rst asserted after the 4th bit -> both oe=0 within the same cycle, tx_ready=1, no pulses; next request 0xF4 completes normally.
